// File: rtl/brainhack_core_pkg.sv
// Shared definitions for the brainhack execution core: opcode and FSM encodings
// plus the default widths used by the core, its stack and its bus interface.
package brainhack_core_pkg;

    localparam int unsigned DEF_TAPE_DATA_W  = 8;
    localparam int unsigned DEF_TAPE_ADDR_W  = 8;
    localparam int unsigned DEF_PRG_ADDR_W   = 8;
    localparam int unsigned DEF_STACK_ADDR_W = 4;
    localparam int unsigned OPCODE_W         = 3;

    // Bit0 set selects the increment / right / open variant of each pair.
    typedef enum logic [OPCODE_W-1:0] {
        OP_OUT   = 3'b000,
        OP_IN    = 3'b001,
        OP_DEC   = 3'b010,
        OP_INC   = 3'b011,
        OP_LEFT  = 3'b100,
        OP_RIGHT = 3'b101,
        OP_CLOSE = 3'b110,
        OP_OPEN  = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_SKIP  = 3'd3,
        S_HALT  = 3'd4,
        S_ERROR = 3'd5
    } state_e;

endpackage

// File: rtl/brainhack_core_if.sv
// Program memory, tape memory and host byte-stream signals of the brainhack core.
// Signal names are from the core's point of view; master = core, slave = environment.
interface brainhack_core_if
    import brainhack_core_pkg::*;
#(
    parameter int unsigned TAPE_DATA_W = DEF_TAPE_DATA_W,
    parameter int unsigned TAPE_ADDR_W = DEF_TAPE_ADDR_W,
    parameter int unsigned PRG_ADDR_W  = DEF_PRG_ADDR_W
);
    logic [PRG_ADDR_W-1:0]  o_prg_addr;
    logic [OPCODE_W-1:0]    i_prg_data;
    logic [TAPE_ADDR_W-1:0] o_tape_addr;
    logic [TAPE_DATA_W-1:0] i_tape_rdata;
    logic                   o_tape_we;
    logic [TAPE_DATA_W-1:0] o_tape_wdata;
    logic                   o_out_valid;
    logic                   i_out_ready;
    logic [TAPE_DATA_W-1:0] o_out_data;
    logic                   i_in_valid;
    logic                   o_in_ready;
    logic [TAPE_DATA_W-1:0] i_in_data;

    modport master (
        output o_prg_addr,  input  i_prg_data,
        output o_tape_addr, input  i_tape_rdata,
        output o_tape_we,   output o_tape_wdata,
        output o_out_valid, input  i_out_ready, output o_out_data,
        input  i_in_valid,  output o_in_ready,  input  i_in_data
    );

    modport slave (
        input  o_prg_addr,  output i_prg_data,
        input  o_tape_addr, output i_tape_rdata,
        input  o_tape_we,   input  o_tape_wdata,
        input  o_out_valid, output i_out_ready, input  o_out_data,
        output i_in_valid,  input  o_in_ready,  output i_in_data
    );

endinterface

// File: rtl/brainhack_stack.sv
// LIFO of loop-start addresses; reset clears the entry count only, not the storage.
module brainhack_stack #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_top,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_wr_idx  = r_count[ADDR_W-1:0];
    assign w_top_idx = w_wr_idx - ADDR_W'(1);
    assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_top     = r_mem[w_top_idx];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clock) begin
        if (w_do_push && !i_reset) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + (ADDR_W+1)'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - (ADDR_W+1)'(1);
        end
    end

endmodule

// File: rtl/brainhack_core.sv
// Brainhack execution core: fetch/execute FSM with forward bracket skip, byte I/O
// handshakes, halt and loop-stack error detection. Memories are external.
module brainhack_core
    import brainhack_core_pkg::*;
#(
    parameter int unsigned TAPE_DATA_W  = DEF_TAPE_DATA_W,
    parameter int unsigned TAPE_ADDR_W  = DEF_TAPE_ADDR_W,
    parameter int unsigned PRG_ADDR_W   = DEF_PRG_ADDR_W,
    parameter int unsigned STACK_ADDR_W = DEF_STACK_ADDR_W
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [PRG_ADDR_W-1:0]   i_prg_len,
    brainhack_core_if.master        bus,
    output logic                    o_busy,
    output logic                    o_halted,
    output logic                    o_error,
    output logic [STACK_ADDR_W:0]   o_stack_count
);
    state_e                 r_state, w_state_nxt;
    logic [PRG_ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic [TAPE_ADDR_W-1:0] r_ptr, w_ptr_nxt;
    opcode_e                r_ir, w_ir_nxt;
    logic [PRG_ADDR_W-1:0]  r_skip_depth, w_skip_nxt;
    logic                   r_busy, r_halted, r_error;

    logic                   w_push, w_pop, w_clear;
    logic                   w_tape_we, w_out_valid, w_in_ready;
    logic [TAPE_DATA_W-1:0] w_tape_wdata;
    logic [PRG_ADDR_W-1:0]  w_stack_top;
    logic                   w_stack_full, w_stack_empty;
    logic                   w_cell_zero, w_at_end;
    logic [PRG_ADDR_W-1:0]  w_pc_inc;
    opcode_e                w_prg_op;

    assign w_cell_zero = (bus.i_tape_rdata == '0);
    assign w_at_end    = (r_pc == i_prg_len);
    assign w_pc_inc    = r_pc + PRG_ADDR_W'(1);
    assign w_prg_op    = opcode_e'(bus.i_prg_data);

    brainhack_stack #(
        .DATA_W (PRG_ADDR_W),
        .ADDR_W (STACK_ADDR_W)
    ) u_stack (
        .i_clock (i_clock),
        .i_reset (i_reset | w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_pc),
        .o_top   (w_stack_top),
        .o_count (o_stack_count),
        .o_full  (w_stack_full),
        .o_empty (w_stack_empty)
    );

    // Next-state, datapath updates and the combinational memory/handshake strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ptr_nxt    = r_ptr;
        w_ir_nxt     = r_ir;
        w_skip_nxt   = r_skip_depth;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        w_tape_we    = 1'b0;
        w_tape_wdata = '0;
        w_out_valid  = 1'b0;
        w_in_ready   = 1'b0;

        case (r_state)
            S_IDLE, S_HALT, S_ERROR: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = '0;
                    w_ptr_nxt   = '0;
                    w_skip_nxt  = '0;
                    w_clear     = 1'b1;
                end
            end
            S_FETCH: begin
                if (w_at_end) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_ir_nxt    = w_prg_op;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = w_pc_inc;
                case (r_ir)
                    OP_INC: begin
                        w_tape_we    = 1'b1;
                        w_tape_wdata = bus.i_tape_rdata + TAPE_DATA_W'(1);
                    end
                    OP_DEC: begin
                        w_tape_we    = 1'b1;
                        w_tape_wdata = bus.i_tape_rdata - TAPE_DATA_W'(1);
                    end
                    OP_RIGHT: w_ptr_nxt = r_ptr + TAPE_ADDR_W'(1);
                    OP_LEFT:  w_ptr_nxt = r_ptr - TAPE_ADDR_W'(1);
                    OP_OPEN: begin
                        if (w_cell_zero) begin
                            w_skip_nxt  = PRG_ADDR_W'(1);
                            w_state_nxt = S_SKIP;
                        end else if (w_stack_full) begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = S_ERROR;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                    OP_CLOSE: begin
                        if (w_stack_empty) begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = S_ERROR;
                        end else if (!w_cell_zero) begin
                            w_pc_nxt = w_stack_top + PRG_ADDR_W'(1);
                        end else begin
                            w_pop = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        w_out_valid = 1'b1;
                        if (!bus.i_out_ready) begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = S_EXEC;
                        end
                    end
                    OP_IN: begin
                        w_in_ready = 1'b1;
                        if (bus.i_in_valid) begin
                            w_tape_we    = 1'b1;
                            w_tape_wdata = bus.i_in_data;
                        end else begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = S_EXEC;
                        end
                    end
                    default: ;
                endcase
            end
            S_SKIP: begin
                if (w_at_end) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_pc_nxt = w_pc_inc;
                    if (w_prg_op == OP_OPEN) begin
                        w_skip_nxt = r_skip_depth + PRG_ADDR_W'(1);
                    end else if (w_prg_op == OP_CLOSE) begin
                        w_skip_nxt = r_skip_depth - PRG_ADDR_W'(1);
                        if (r_skip_depth == PRG_ADDR_W'(1)) begin
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_ptr        <= '0;
            r_ir         <= OP_OUT;
            r_skip_depth <= '0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ptr        <= w_ptr_nxt;
            r_ir         <= w_ir_nxt;
            r_skip_depth <= w_skip_nxt;
            r_busy       <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC) ||
                            (w_state_nxt == S_SKIP);
            r_halted     <= (w_state_nxt == S_HALT);
            r_error      <= (w_state_nxt == S_ERROR);
        end
    end

    // Strobes are suppressed while reset is asserted so no write or transfer can slip out.
    assign bus.o_prg_addr   = r_pc;
    assign bus.o_tape_addr  = r_ptr;
    assign bus.o_tape_we    = w_tape_we & ~i_reset;
    assign bus.o_tape_wdata = w_tape_wdata;
    assign bus.o_out_valid  = w_out_valid & ~i_reset;
    assign bus.o_out_data   = bus.i_tape_rdata;
    assign bus.o_in_ready   = w_in_ready & ~i_reset;
    assign o_busy           = r_busy;
    assign o_halted         = r_halted;
    assign o_error          = r_error;

endmodule
